// File: rtl/gray_codec_pkg.sv
// gray_codec shared types and helpers.
// Mode enum, width-generic conversion functions, stage slicing.
package gray_codec_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } gray_mode_e;

    // Bits resolved per pipeline stage (ceiling division).
    function automatic int bits_per_stage(input int n, input int stages);
        return (n + stages - 1) / stages;
    endfunction

    // Binary to Gray over the low n bits; upper bits return 0.
    function automatic logic [MAX_W-1:0] bin2gray_f(
        input logic [MAX_W-1:0] b,
        input int               n
    );
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n) m[i] = b[i];
        end
        return m ^ (m >> 1);
    endfunction

    // Gray to binary over the low n bits (prefix XOR from MSB).
    function automatic logic [MAX_W-1:0] gray2bin_f(
        input logic [MAX_W-1:0] g,
        input int               n
    );
        logic [MAX_W-1:0] r;
        logic             acc;
        r   = '0;
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < n) begin
                acc  = acc ^ g[i];
                r[i] = acc;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// gray_codec pipeline slice.
// Resolves Gray bits HI..LO of a word; the first slice also does binary->Gray.
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int N     = 4,
    parameter int HI    = 3,
    parameter int LO    = 0,
    parameter bit FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         in_mode,
    input  logic         in_adj,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_mode,
    output logic         out_adj
);

    logic         valid_q;
    logic         valid_d;
    logic         load;
    logic [N-1:0] data_q;
    logic [N-1:0] data_d;
    logic         mode_q;
    logic         adj_q;
    logic         acc;

    assign load = in_valid && (!valid_q || out_ready);

    // Bits above HI are already binary; fold them into this slice's prefix XOR.
    always_comb begin
        data_d = in_data;
        acc    = 1'b0;
        if (in_mode == MODE_G2B) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i <= HI && i >= LO) begin
                    acc       = acc ^ in_data[i];
                    data_d[i] = acc;
                end else begin
                    acc = in_data[i];
                end
            end
        end else if (FIRST) begin
            data_d = in_data ^ (in_data >> 1);
        end
    end

    // Slice occupancy: fill on load, empty when the word leaves unreplaced.
    always_comb begin
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers; payload holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
            adj_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= data_d;
                mode_q <= in_mode;
                adj_q  <= in_adj;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;
    assign out_adj   = adj_q;

endmodule

// File: rtl/gray_codec.sv
// gray_codec: pipelined binary<->Gray converter with valid/ready streaming.
// Optional Gray-input adjacency check: define GRAY_CODEC_ADJ_CHECK_EN.
module gray_codec
    import gray_codec_pkg::*;
#(
    parameter int N      = 4,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_mode,
    output logic         adj_err
);

    localparam int BPS = bits_per_stage(N, STAGES);

    logic [STAGES:0]        vld;
    logic [STAGES:0]        rdy;
    logic [STAGES:0]        md;
    logic [STAGES:0]        adj;
    logic [STAGES:0][N-1:0] dat;

    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign md[0]  = mode;

    // Ready ripples back: a slice accepts if empty or its word moves on.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_codec_stage #(
            .N    (N),
            .HI   (N - 1 - k * BPS),
            .LO   (N - (k + 1) * BPS),
            .FIRST(k == 0)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_valid (vld[k]),
            .in_data  (dat[k]),
            .in_mode  (md[k]),
            .in_adj   (adj[k]),
            .out_ready(rdy[k+1]),
            .out_valid(vld[k+1]),
            .out_data (dat[k+1]),
            .out_mode (md[k+1]),
            .out_adj  (adj[k+1])
        );
    end

`ifdef GRAY_CODEC_ADJ_CHECK_EN
    logic [N-1:0] hist_q;
    logic [N-1:0] hist_d;
    logic         seen_q;
    logic         seen_d;
    logic         g_accept;

    assign g_accept = in_valid && rdy[0] && (mode == MODE_G2B);
    assign adj[0]   = (mode == MODE_G2B) && seen_q
                    && !$onehot(in_data ^ hist_q);

    // Remember the last accepted Gray-mode word.
    always_comb begin
        hist_d = hist_q;
        seen_d = seen_q;
        if (g_accept) begin
            hist_d = in_data;
            seen_d = 1'b1;
        end
    end

    // History register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            seen_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

    assign adj_err = adj[STAGES];
`else
    logic adj_unused;

    assign adj[0]     = 1'b0;
    assign adj_unused = adj[STAGES];
    assign adj_err    = 1'b0;
`endif

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign out_data  = dat[STAGES];
    assign out_mode  = md[STAGES];

endmodule

// File: tb/tb_gray_codec.sv
// Directed testbench for gray_codec.
// Three instances: N4/S1, N4/S2, N8/S4.
module tb_gray_codec;
    import gray_codec_pkg::*;

    logic clk;
    logic rst;

    logic       a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic       a_out_mode, a_adj_err;
    logic [3:0] a_in_data, a_out_data;

    logic       b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_out_mode, b_adj_err;
    logic [3:0] b_in_data, b_out_data;

    logic       c_mode, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic       c_out_mode, c_adj_err;
    logic [7:0] c_in_data, c_out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [MAX_W-1:0] wtmp;
    logic             acc;
    int               c_idx;
    int               got;

    logic [3:0] adj_in  [8] = '{4'h0, 4'h1, 4'h3, 4'hF, 4'h0, 4'h8, 4'h0, 4'h0};
    logic       adj_md  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] adj_od  [8] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h0, 4'hF, 4'h0, 4'h0};
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    logic       adj_ex  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic       adj_ex  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    logic [3:0] alt_in  [8] = '{4'h3, 4'h9, 4'hC, 4'h5, 4'hF, 4'h0, 4'h8, 4'h6};
    logic [3:0] alt_ex  [8] = '{4'h2, 4'hE, 4'hA, 4'h6, 4'h8, 4'h0, 4'hC, 4'h4};

    logic [7:0] c_in    [5] = '{8'hB4, 8'h5A, 8'hFF, 8'h80, 8'h01};
    logic       c_md    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] c_ex    [5] = '{8'hD8, 8'h77, 8'hAA, 8'hC0, 8'h01};

    gray_codec #(.N(4), .STAGES(1)) u_a (
        .clk(clk), .rst(rst), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_mode(a_out_mode), .adj_err(a_adj_err)
    );

    gray_codec #(.N(4), .STAGES(2)) u_b (
        .clk(clk), .rst(rst), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_mode(b_out_mode), .adj_err(b_adj_err)
    );

    gray_codec #(.N(8), .STAGES(4)) u_c (
        .clk(clk), .rst(rst), .mode(c_mode),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_mode(c_out_mode), .adj_err(c_adj_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {a_mode, a_in_valid, a_out_ready, a_in_data} = '0;
        {b_mode, b_in_valid, b_out_ready, b_in_data} = '0;
        {c_mode, c_in_valid, c_out_ready, c_in_data} = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_mode", a_out_mode, 0);
        check("rst_adj_err", a_adj_err, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_c_out_data", c_out_data, 0);
        check("rst_c_in_ready", c_in_ready, 1);

        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1;
            a_mode     = adj_md[i];
            a_in_data  = adj_in[i];
            tick();
            check("adj_valid", a_out_valid, 1);
            check("adj_data", a_out_data, adj_od[i]);
            check("adj_mode", a_out_mode, adj_md[i]);
            check("adj_flag", a_adj_err, adj_ex[i]);
        end

        a_mode    = 1'b0;
        a_in_data = 4'b1011;
        tick();
        check("b2g_1011", a_out_data, 4'b1110);
        for (int v = 0; v < 16; v++) begin
            a_in_data = 4'(v);
            tick();
            wtmp = bin2gray_f(64'(v), 4);
            check("b2g_sweep", a_out_data, wtmp);
            wtmp = gray2bin_f(64'(a_out_data), 4);
            check("b2g_roundtrip", wtmp, v);
        end
        a_in_valid = 1'b0;
        tick();
        check("a_idle", a_out_valid, 0);

        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_mode      = 1'b1;
        b_in_data   = 4'b1110;
        tick();
        check("b_lat_early", b_out_valid, 0);
        b_in_valid = 1'b0;
        tick();
        check("b_lat_valid", b_out_valid, 1);
        check("b_g2b_1110", b_out_data, 4'b1011);
        check("b_g2b_mode", b_out_mode, 1);
        tick();
        check("b_lat_gone", b_out_valid, 0);

        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                b_in_valid = 1'b1;
                b_mode     = i[0];
                b_in_data  = alt_in[i];
                check("alt_in_ready", b_in_ready, 1);
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 8) begin
                check("alt_valid", b_out_valid, 1);
                check("alt_data", b_out_data, alt_ex[i-1]);
                check("alt_mode", b_out_mode, (i - 1) % 2);
            end
        end
        check("alt_drained", b_out_valid, 0);

        c_out_ready = 1'b0;
        c_idx       = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (c_idx < 5) begin
                c_in_valid = 1'b1;
                c_in_data  = c_in[c_idx];
                c_mode     = c_md[c_idx];
            end else begin
                c_in_valid = 1'b0;
            end
            acc = c_in_valid && c_in_ready;
            tick();
            if (acc) c_idx++;
        end
        check("bp_accepted", c_idx, 4);
        check("bp_in_ready", c_in_ready, 0);
        check("bp_out_valid", c_out_valid, 1);
        check("bp_out_data", c_out_data, c_ex[0]);
        check("bp_out_mode", c_out_mode, c_md[0]);
        tick();
        tick();
        check("bp_stable_data", c_out_data, c_ex[0]);
        check("bp_stable_valid", c_out_valid, 1);

        c_out_ready = 1'b1;
        #1;
        check("bp_ready_return", c_in_ready, 1);
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            if (c_idx < 5) begin
                c_in_valid = 1'b1;
                c_in_data  = c_in[c_idx];
                c_mode     = c_md[c_idx];
            end else begin
                c_in_valid = 1'b0;
            end
            acc = c_in_valid && c_in_ready;
            if (c_out_valid) begin
                check("drain_data", c_out_data, c_ex[got]);
                check("drain_mode", c_out_mode, c_md[got]);
                got++;
            end
            tick();
            if (acc) c_idx++;
        end
        check("drain_count", got, 5);
        c_in_valid = 1'b0;
        tick();
        check("drain_no_dup", c_out_valid, 0);

        c_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = c_in[i];
            c_mode     = c_md[i];
            tick();
        end
        rst        = 1'b1;
        c_in_data  = 8'h33;
        c_out_ready = 1'b1;
        tick();
        rst        = 1'b0;
        c_in_valid = 1'b0;
        #1;
        check("mid_rst_valid", c_out_valid, 0);
        check("mid_rst_ready", c_in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_stale", c_out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
